uart_tx_pacer: RTL



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_byte_fifo.sv | 60 ++++++
 rtl/uart_tx_pacer.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART timing defaults, derived-constant helpers and the
//            pacer state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEF_UART_BPS   = 9600;
    localparam int DEF_CLK_FREQ   = 50_000_000;
    localparam int DEF_FRAME_BITS = 12;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // Cycles between successive issues to the transmitter.
    function automatic int frame_spacing(input int clk_freq, input int uart_bps,
                                         input int frame_bits);
        return frame_bits * baud_cnt_max(clk_freq, uart_bps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_fifo
// Purpose  : Synchronous byte FIFO with combinational head read and count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       full,
    output logic                       empty
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = c_AW + 1;

    logic [7:0]        r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic              w_wr;
    logic              w_rd;

    // Guard against writes when full / reads when empty from any caller.
    assign w_wr    = wr_en & ~full;
    assign w_rd    = rd_en & ~empty;
    assign full    = (r_cnt == c_CNT_W'(DEPTH));
    assign empty   = (r_cnt == '0);
    assign cnt     = r_cnt;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_pacer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pacer
// Purpose  : Buffers producer bytes and issues them to the UART transmitter
//            one frame time apart, holding po_data for the whole frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_pacer #(
    parameter int UART_BPS   = uart_pkg::DEF_UART_BPS,
    parameter int CLK_FREQ   = uart_pkg::DEF_CLK_FREQ,
    parameter int FRAME_BITS = uart_pkg::DEF_FRAME_BITS,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [7:0]                    po_data,
    output logic                          po_flag,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          ovf
);

    import uart_pkg::*;

    localparam int c_SPACING = frame_spacing(CLK_FREQ, UART_BPS, FRAME_BITS);
    localparam int c_GAP_W   = (c_SPACING > 1) ? $clog2(c_SPACING) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_SPACING - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_GAP_W-1:0] w_gap_nxt;
    logic               w_issue;
    logic [7:0]         r_po_data;
    logic               r_po_flag;
    logic               r_ovf;
    logic               w_push;
    logic [7:0]         w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    // Ready comes from the registered count only, so a same-cycle pop
    // never opens a slot for the producer.
    assign in_ready = ~w_fifo_full;
    assign w_push   = in_valid & in_ready;
    assign po_data  = r_po_data;
    assign po_flag  = r_po_flag;
    assign ovf      = r_ovf;
    assign busy     = (r_state != ST_IDLE) || !w_fifo_empty;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (w_push),
        .wr_data (in_data),
        .rd_en   (w_issue),
        .rd_data (w_head),
        .cnt     (fifo_cnt),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_issue     = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_gap_nxt = '0;
                    if (!w_fifo_empty) w_issue = 1'b1;
                    else               w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_gap_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_po_data <= 8'h00;
            r_po_flag <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_po_flag <= w_issue;
            r_ovf     <= in_valid & ~in_ready;
            if (w_issue) r_po_data <= w_head;
        end
    end

endmodule
`default_nettype wire
